apb_master_arbiter: RTL
=======================

Name: apb_master_arbiter

Overview:
- Two-requester APB master controller.
- Arbitrates between two local command ports with round-robin and sequences the winner through the APB SETUP and ACCESS phases.
- Returns PRDATA/PSLVERR to the granted requester.
- Drives the apb_inf master-side signals (PSEL, PENABLE, PWRITE, PADDR, PWDATA) and samples the slave-side signals (PREADY, PRDATA, PSLVERR).

Parameters:
ADDR_WIDTH, 8, width of PADDR and reqN_addr
DATA_WIDTH, 8, width of PWDATA/PRDATA and request data
TIMEOUT_CYCLES, 16, ACCESS-phase cycle limit; used only when APB_TIMEOUT_EN is defined

Ports:
PCLK  in  1  single clock, all logic on rising edge
PRESETn  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 command valid
req0_ready  out  1  requester 0 command accepted this cycle
req0_write  in  1  1=write, 0=read
req0_addr  in  ADDR_WIDTH  command address
req0_wdata  in  DATA_WIDTH  write data
req0_done  out  1  one-cycle completion pulse
req0_rdata  out  DATA_WIDTH  read data, valid with req0_done
req0_err  out  1  error status, valid with req0_done
req1_*  same set as req0_*, for requester 1
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_WIDTH  APB address
PWDATA  out  DATA_WIDTH  APB write data
PREADY  in  1  slave ready
PRDATA  in  DATA_WIDTH  slave read data
PSLVERR  in  1  slave error

Behaviour:
- Reset (PRESETn=0, asynchronous):
  - state=IDLE, last_grant=1 (requester 0 wins first).
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA = 0.
  - All reqN_ready, reqN_done, reqN_rdata, reqN_err = 0.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - reqN_ready is combinational: state==IDLE && grant==N && reqN_valid.
  - Only one requester wins: the one that did not win last.
  - If only one requester is valid, it wins regardless of last_grant.
  - Accept = valid && ready. On accept:
    - Latch write/addr/wdata into PWRITE/PADDR/PWDATA.
    - Update last_grant.
    - Next state SETUP.
  - No valid: stay IDLE, PSEL=0.
- SETUP (exactly 1 cycle): PSEL=1, PENABLE=0, next state ACCESS.
- ACCESS: PSEL=1, PENABLE=1.
  - PADDR/PWRITE/PWDATA are held stable from SETUP until completion.
  - PREADY=0: stay in ACCESS (unbounded wait unless APB_TIMEOUT_EN).
  - PREADY=1 at a rising edge: complete. On that edge:
    - PSEL and PENABLE go 0; state goes to IDLE.
    - Granted reqN_done=1 for exactly one cycle.
    - reqN_rdata = PRDATA for reads, 0 for writes.
    - reqN_err = PSLVERR.
- Latency:
  - Accept at cycle N → SETUP at N+1 → ACCESS at N+2.
  - Zero-wait slave: done at N+3.
  - A new accept is allowed in the same cycle done is asserted (N+3), giving back-to-back 3-cycle transfers.
- Outside a done pulse:
  - reqN_done = 0.
  - reqN_rdata and reqN_err hold their last values.
- The non-granted requester sees ready=0 and done=0 throughout; its valid must stay asserted until ready.
- Simultaneous valid on both requesters every cycle: grants strictly alternate 0,1,0,1.
- Reset mid-transfer: the bus returns to idle immediately. No done is issued; the in-flight command is dropped.
- PSLVERR is sampled only when PENABLE && PREADY; ignored otherwise.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- When defined:
  - A counter (width $clog2(TIMEOUT_CYCLES+1)) clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT_CYCLES, abort: PSEL=0, PENABLE=0, state IDLE.
  - Granted reqN_done=1 with reqN_err=1 and reqN_rdata=0.
  - PREADY=1 on the same edge as the limit takes priority: normal completion.
- When undefined: no counter; ACCESS waits indefinitely for PREADY.

Test Plan:
- Reset, then req0 write addr=0x10 wdata=0xA5 with PREADY held 1 → PSEL at N+1, PENABLE at N+2 with PADDR=0x10, PWDATA=0xA5, PWRITE=1; req0_done at N+3, req0_err=0, req0_rdata=0.
- req1 read addr=0x22; slave returns PRDATA=0x5C with PREADY low 3 cycles → ACCESS lasts 4 cycles with PADDR stable; req1_done with req1_rdata=0x5C.
- Both valid continuously for 4 commands → grant order 0,1,0,1; each done pulse goes only to its owner; transfers are back-to-back at 3-cycle spacing.
- Read with PSLVERR=1 at PREADY → reqN_err=1 and done pulse; the next transfer shows err=0.
- PRESETn driven low in ACCESS → PSEL/PENABLE=0 asynchronously, no done; after release, req0 wins first.
- APB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, PREADY stuck 0 → abort after 16 ACCESS cycles with done=1, err=1, rdata=0. Without the macro, the bench shows the controller still in ACCESS after 100 cycles.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: two-requester APB master with round-robin arbitration.
// The winning command is carried through the APB SETUP and ACCESS phases,
// and the completion result is returned to whichever requester owns it.
// Optional feature macro: APB_TIMEOUT_EN (ACCESS-phase timeout abort).
module apb_master_arbiter #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_done,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  output logic                  req0_err,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_done,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic                  req1_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state, state_next;
  logic   last_grant;
  logic   grant;
  logic   owner;
  logic   accept;
  logic   complete;
  logic   abort;

  // Round-robin pick: alternate when both ask, otherwise the lone requester wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign accept     = PRESETn && (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;

  // PSLVERR and PRDATA only count when the slave completes an ACCESS cycle.
  assign complete = (state == ACCESS) && PREADY;

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tcount;

  // Count stalled ACCESS cycles; the abort fires on the edge the count would reach the limit.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tcount <= '0;
    end else if (state == SETUP) begin
      tcount <= '0;
    end else if ((state == ACCESS) && !PREADY) begin
      tcount <= tcount + 1'b1;
    end
  end

  assign abort = (state == ACCESS) && !PREADY && (tcount == CW'(TIMEOUT_CYCLES - 1));
`else
  // Without the timeout the controller waits on PREADY forever.
  assign abort = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  // State register; reset drops any in-flight transfer immediately.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the APB phase strobes, which follow the state directly.
  always_comb begin
    state_next = state;
    PSEL       = 1'b0;
    PENABLE    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SETUP;
        end
      end
      SETUP: begin
        PSEL       = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (complete || abort) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Command capture on accept, and result return to the owning requester on completion.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      req0_done  <= 1'b0;
      req0_rdata <= '0;
      req0_err   <= 1'b0;
      req1_done  <= 1'b0;
      req1_rdata <= '0;
      req1_err   <= 1'b0;
    end else begin
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      if (accept) begin
        owner      <= grant;
        last_grant <= grant;
        PWRITE     <= grant ? req1_write : req0_write;
        PADDR      <= grant ? req1_addr  : req0_addr;
        PWDATA     <= grant ? req1_wdata : req0_wdata;
      end
      if (complete || abort) begin
        if (!owner) begin
          req0_done  <= 1'b1;
          req0_rdata <= (complete && !PWRITE) ? PRDATA : '0;
          req0_err   <= complete ? PSLVERR : 1'b1;
        end else begin
          req1_done  <= 1'b1;
          req1_rdata <= (complete && !PWRITE) ? PRDATA : '0;
          req1_err   <= complete ? PSLVERR : 1'b1;
        end
      end
    end
  end

endmodule
